wb_master_ctrl: RTL and testbench

- Wishbone classic single-transfer bus master that drives `wishbone_slave` directly.
- Accepts read/write commands from a core-side valid/ready interface and buffers them in a small command FIFO.
- Runs one Wishbone cycle per command, waits for ACK_I under a timeout, and returns read data plus an error flag on a response valid/ready interface.

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_master_ctrl_if.sv | 31 +++
 rtl/wb_cmd_fifo.sv | 34 +++
 rtl/wb_master_ctrl.sv | 100 ++++++++++
 tb/tb_wb_master_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared command type, FSM states and default widths for the Wishbone master
package wb_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_cmd_t;
  typedef enum logic [1:0] {IDLE, BUS, RESP} wb_mst_state_e;
endpackage

// File: rtl/wb_master_ctrl_if.sv
// wb_master_ctrl_if: core-side command/response channels plus the Wishbone master bus
interface wb_master_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] ADR_O;
  logic [DW-1:0] DAT_O;
  logic [DW-1:0] DAT_I;
  logic          WE_O;
  logic          SEL_O;
  logic          STB_O;
  logic          CYC_O;
  logic          ACK_I;
  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, DAT_I, ACK_I,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err, ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, DAT_I, ACK_I,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err, ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O
  );
endinterface

// File: rtl/wb_cmd_fifo.sv
// wb_cmd_fifo: synchronous command FIFO; pointers carry an extra MSB to tell full from empty
module wb_cmd_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    CLK_I,
  input  logic    RST_I,
  input  logic    push,
  input  logic    pop,
  input  wb_cmd_t din,
  output wb_cmd_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(DEPTH);
  wb_cmd_t     mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
  assign head  = mem[rd_ptr[PW-1:0]];
  always_ff @(posedge CLK_I)
    if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: queued single-transfer Wishbone classic master with ACK timeout
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int AW         = WB_AW,
  parameter int DW         = WB_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic            CLK_I,
  input logic            RST_I,
  wb_master_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  wb_mst_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] adr_n;
  logic [DW-1:0] dat_n, rsp_dat_n;
  logic          we_n, cyc_n, rsp_valid_n, rsp_err_n;
  logic          full, empty, pop;
  wb_cmd_t       cmd_in, head;
  assign cmd_in        = '{we: bus.cmd_we, adr: bus.cmd_adr, dat: bus.cmd_dat};
  assign bus.cmd_ready = !full;
  wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (bus.cmd_valid),
    .pop   (pop),
    .din   (cmd_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  // STB_O and SEL_O always track CYC_O for single transfers, so one flag drives all three
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    adr_n       = bus.ADR_O;
    dat_n       = bus.DAT_O;
    we_n        = bus.WE_O;
    cyc_n       = bus.CYC_O;
    rsp_valid_n = bus.rsp_valid;
    rsp_dat_n   = bus.rsp_dat;
    rsp_err_n   = bus.rsp_err;
    pop         = 1'b0;
    unique case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        adr_n   = head.adr;
        dat_n   = head.we ? head.dat : '0;
        we_n    = head.we;
        cyc_n   = 1'b1;
        cnt_n   = '0;
        state_n = BUS;
      end
      BUS: if (bus.ACK_I || cnt == CW'(TIMEOUT - 1)) begin
        rsp_dat_n   = (bus.ACK_I && !bus.WE_O) ? bus.DAT_I : '0;
        rsp_err_n   = !bus.ACK_I;
        rsp_valid_n = 1'b1;
        cyc_n       = 1'b0;
        we_n        = 1'b0;
        state_n     = RESP;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_n = 1'b0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.ADR_O     <= '0;
      bus.DAT_O     <= '0;
      bus.WE_O      <= 1'b0;
      bus.CYC_O     <= 1'b0;
      bus.STB_O     <= 1'b0;
      bus.SEL_O     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_dat   <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus.ADR_O     <= adr_n;
      bus.DAT_O     <= dat_n;
      bus.WE_O      <= we_n;
      bus.CYC_O     <= cyc_n;
      bus.STB_O     <= cyc_n;
      bus.SEL_O     <= cyc_n;
      bus.rsp_valid <= rsp_valid_n;
      bus.rsp_dat   <= rsp_dat_n;
      bus.rsp_err   <= rsp_err_n;
    end
  end
endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl: directed and randomized checks of wb_master_ctrl against a memory-slave reference model
module tb_wb_master_ctrl;
  logic clk, rst;
  int   errors = 0;
  int   checks = 0;
  wb_master_ctrl_if #(.AW(32), .DW(32)) bus ();
  wb_master_ctrl #(.AW(32), .DW(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] smem [64];
  logic [31:0] ref_mem [64];
  logic        init_mem, spur, ovr_en;
  logic [31:0] ovr_dat;
  int          ack_at;
  int          stb_k = 1;
  int          last_len = 0;

  function automatic logic [31:0] seed(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // slave: acks on the ack_at-th cycle of a strobe (0 = never), stores writes at the ack edge
  assign bus.ACK_I = spur || (ack_at != 0 && bus.STB_O && stb_k == ack_at);
  assign bus.DAT_I = ovr_en ? ovr_dat : smem[bus.ADR_O[7:2]];
  always @(posedge clk) begin
    stb_k <= bus.STB_O ? stb_k + 1 : 1;
    if (bus.STB_O) last_len <= stb_k;
    if (init_mem) for (int i = 0; i < 64; i++) smem[i] <= seed(i);
    else if (bus.STB_O && bus.ACK_I && bus.WE_O) smem[bus.ADR_O[7:2]] <= bus.DAT_O;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected outcome of one command against a slave that acks on cycle 'at'
  task automatic model(input logic we, input logic [5:0] idx, input logic [31:0] dat, input int at,
                       output logic [31:0] ed, output logic ee, output int elen);
    logic acked;
    acked = at >= 1 && at <= 16;
    ee    = !acked;
    ed    = (acked && !we) ? ref_mem[idx] : 32'h0;
    elen  = acked ? at : 16;
    if (acked && we) ref_mem[idx] = dat;
  endtask

  task automatic try_push(input logic we, input logic [31:0] adr, input logic [31:0] dat, output logic acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    acc           = bus.cmd_ready;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) try_push(we, adr, dat, acc);
    check("push_accepted", 64'(acc), 64'(1));
  endtask

  task automatic get_rsp(output logic [31:0] dat, output logic err, output logic cyc);
    logic ok;
    ok  = 1'b0;
    dat = 'x;
    err = 1'bx;
    cyc = 1'bx;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.rsp_valid) begin
        dat = bus.rsp_dat;
        err = bus.rsp_err;
        cyc = bus.CYC_O;
        ok  = 1'b1;
      end
      @(negedge clk);
    end
    check("rsp_arrived", 64'(ok), 64'(1));
  endtask

  task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat, input int at);
    logic [31:0] ed, rd;
    logic        ee, re, rc;
    int          elen;
    model(we, adr[7:2], dat, at, ed, ee, elen);
    ack_at = at;
    push(we, adr, dat);
    get_rsp(rd, re, rc);
    check({tag, "_dat"}, 64'(rd), 64'(ed));
    check({tag, "_err"}, 64'(re), 64'(ee));
    check({tag, "_stblen"}, 64'(last_len), 64'(elen));
  endtask

  initial begin
    logic [31:0] rd, adr;
    logic        re, rc, acc;
    logic [5:0]  idx;
    int          cnt_rv, cnt_cyc;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    rst = 1'b1; init_mem = 1'b1; spur = 1'b0; ovr_en = 1'b0; ovr_dat = '0; ack_at = 1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; init_mem = 1'b0;
    check("rst_cyc", 64'(bus.CYC_O), 64'(0));
    check("rst_stb", 64'(bus.STB_O), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_adr", 64'(bus.ADR_O), 64'(0));
    check("rst_rsp_dat", 64'(bus.rsp_dat), 64'(0));
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // write then read back, with an idle gap on CYC_O between the two bus cycles
    ack_at = 1;
    push(1'b1, 32'h10, 32'hDEAD_BEEF);
    push(1'b0, 32'h10, 32'h0);
    get_rsp(rd, re, rc);
    check("t1_wr_dat", 64'(rd), 64'(0));
    check("t1_wr_err", 64'(re), 64'(0));
    check("t1_gap_a", 64'(rc), 64'(0));
    check("t1_gap_b", 64'(bus.CYC_O), 64'(0));
    get_rsp(rd, re, rc);
    check("t1_rd_dat", 64'(rd), 64'(32'hDEAD_BEEF));
    check("t1_rd_err", 64'(re), 64'(0));
    ref_mem[4] = 32'hDEAD_BEEF;

    // timeout: no ack at all
    ack_at = 0;
    push(1'b0, 32'h40, 32'h0);
    get_rsp(rd, re, rc);
    check("t2_dat", 64'(rd), 64'(0));
    check("t2_err", 64'(re), 64'(1));
    check("t2_cyc", 64'(rc), 64'(0));
    check("t2_stblen", 64'(last_len), 64'(16));

    // ack on the final allowed cycle wins over the timeout
    ack_at = 16; ovr_en = 1'b1; ovr_dat = 32'h1234_5678;
    push(1'b0, 32'h20, 32'h0);
    get_rsp(rd, re, rc);
    check("t3_dat", 64'(rd), 64'(32'h1234_5678));
    check("t3_err", 64'(re), 64'(0));
    check("t3_stblen", 64'(last_len), 64'(16));
    ovr_en = 1'b0;

    // fill the FIFO behind a stalled response
    ack_at = 1; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      try_push(1'b0, 32'h80 + 32'(i) * 4, 32'h0, acc);
      check($sformatf("t4_accept%0d", i), 64'(acc), 64'(i < 5));
    end
    repeat (3) @(negedge clk);
    check("t4_full_ready", 64'(bus.cmd_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(rd, re, rc);
      check($sformatf("t4_rsp%0d_dat", i), 64'(rd), 64'(seed(32 + i)));
      check($sformatf("t4_rsp%0d_err", i), 64'(re), 64'(0));
    end

    // reset while a read is on the bus
    ack_at = 0;
    push(1'b0, 32'h44, 32'h0);
    for (int i = 0; i < 20 && !bus.STB_O; i++) @(negedge clk);
    check("t5_stb", 64'(bus.STB_O), 64'(1));
    check("t5_adr", 64'(bus.ADR_O), 64'(32'h44));
    check("t5_dat_o", 64'(bus.DAT_O), 64'(0));
    check("t5_we", 64'(bus.WE_O), 64'(0));
    check("t5_sel", 64'(bus.SEL_O), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_outs", 64'({bus.CYC_O, bus.STB_O, bus.WE_O, bus.SEL_O, bus.rsp_valid, bus.rsp_err}), 64'(0));
    check("t5_adr0", 64'(bus.ADR_O), 64'(0));
    check("t5_rsp_dat0", 64'(bus.rsp_dat), 64'(0));
    check("t5_ready", 64'(bus.cmd_ready), 64'(1));
    cnt_rv = 0; cnt_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      cnt_rv  += int'(bus.rsp_valid);
      cnt_cyc += int'(bus.CYC_O);
      @(negedge clk);
    end
    check("t5_no_rsp", 64'(cnt_rv), 64'(0));
    check("t5_no_cyc", 64'(cnt_cyc), 64'(0));

    // spurious ack while idle
    spur = 1'b1; cnt_rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt_rv += int'(bus.rsp_valid);
    end
    spur = 1'b0;
    check("t6_no_rsp", 64'(cnt_rv), 64'(0));
    run_cmd("t6_read", 1'b0, 32'h4, 32'h0, 1);

    // randomized traffic against the reference memory
    for (int n = 0; n < 24; n++) begin
      idx = 6'($urandom_range(0, 63));
      adr = ($urandom() & 32'hFFFF_FF03) | {24'h0, idx, 2'b00};
      run_cmd($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), adr, $urandom(), $urandom_range(1, 20));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
